fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, meaning number of write requesters (2..16).
REQ-002 The block SHALL have parameter Width, default 8, meaning data width, equal to the async_fifo Width.
REQ-003 The block SHALL have parameter MaxBurst, default 4, meaning maximum consecutive beats per grant (>=1).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 Port clk_wr, input, 1, is the write-domain clock; all state is updated on its rising edge.
REQ-006 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-007 Port i_req_valid, input, NumReq, is the per-requester beat-valid signal.
REQ-008 Port i_req_data, input, NumReq*Width, carries requester k's data in bits [k*Width +: Width].
REQ-009 Port o_req_ready, output, NumReq, is the per-requester beat-accepted signal.
REQ-010 Port i_wr_full, input, 1, is the FIFO full flag (o_wr_full of async_fifo).
REQ-011 Port o_wr_en, output, 1, is the FIFO write enable (to i_wr_en).
REQ-012 Port o_wr_data, output, Width, is the FIFO write data (to i_wr_data).
REQ-013 Port o_grant, output, NumReq, is the one-hot current grant; it is all-zero when idle.
REQ-014 Port o_busy, output, 1, is high while the state machine is in GRANT.

Function
REQ-015 State machine SHALL have two states: IDLE (no grant) and GRANT (one requester g owns the write port).
REQ-016 Internal registers SHALL be: state, grant index g, round-robin pointer rr_ptr (clog2(NumReq) bits), beat counter cnt (clog2(MaxBurst+1) bits).
REQ-017 Arbitration SHALL select the first k with i_req_valid[k]=1, searching from rr_ptr upward modulo NumReq.
REQ-018 IDLE with any valid request SHALL move to GRANT next edge, with g=selected and cnt=0; with no valid request, state SHALL stay IDLE.
REQ-019 The first beat SHALL be writable in the cycle after the request is first seen in IDLE (1-cycle grant latency).
REQ-020 In GRANT: o_wr_en = i_req_valid[g] & ~i_wr_full; o_req_ready[g] = ~i_wr_full; all other ready bits SHALL be 0; all are combinational.
REQ-021 o_wr_data SHALL equal requester g's data slice in GRANT and 0 in IDLE; o_grant SHALL be the one-hot encoding of g in GRANT and 0 in IDLE.
REQ-022 Each accepted beat (o_wr_en=1) SHALL increment cnt.
REQ-023 Release SHALL occur when an accepted beat makes cnt reach MaxBurst, or when i_req_valid[g]=0.
REQ-024 On release, rr_ptr SHALL be set to (g+1) mod NumReq.
REQ-025 On release, arbitration SHALL rerun in the same cycle from (g+1) mod NumReq over the current i_req_valid; if a requester is found, state SHALL stay GRANT with the new g and cnt=0 (no bubble), otherwise state SHALL go to IDLE.
REQ-026 The released requester SHALL be re-grantable immediately if it is the only valid one.
REQ-027 While i_wr_full=1: o_wr_en=0, all ready=0, cnt and g SHALL hold; no timeout SHALL apply.
REQ-028 If i_req_valid[g] drops while full, the grant SHALL be released per REQ-023.
REQ-029 Requesters SHALL hold valid and data stable until ready; the arbiter SHALL NOT check this rule.
REQ-030 MaxBurst=1 SHALL give per-beat round robin.
REQ-031 At most one o_grant bit SHALL be high, and o_wr_en SHALL never be high with i_wr_full=1.

Reset
REQ-032 While rst_n=0, regardless of clk_wr: state=IDLE, g=0, rr_ptr=0, cnt=0.
REQ-033 While rst_n=0, outputs SHALL be o_grant=0, o_busy=0, o_wr_en=0, o_req_ready=0, o_wr_data=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst without a partial write in the reset cycle.
REQ-035 After rst_n deasserts, arbitration SHALL resume from requester 0.

Verification
REQ-036 Single requester: valid[0]=1 continuously, full=0, MaxBurst=4 -> o_wr_en=1 every cycle from cycle 1 after reset release; o_grant=0001 throughout; no bubble at the 4-beat boundary.
REQ-037 All four requesters valid continuously -> grant sequence 0,1,2,3,0 of 4 beats each; o_wr_en continuously 1; data order matches the grant order.
REQ-038 Full asserted for 3 cycles after beat 2 of requester 1 -> o_wr_en=0 and ready=0 for those 3 cycles; grant held; beats 3-4 follow; then grant passes to 2.
REQ-039 Requester 2 drops valid after 2 beats while 3 is valid -> next edge o_grant=1000, cnt=0; rr_ptr=3.
REQ-040 rst_n pulsed low mid-burst -> outputs go to 0 asynchronously; after release, the first grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: NumReq requesters share one FIFO write port,
// each grant lasting up to MaxBurst accepted beats, with zero-bubble handover.
module fifo_wr_arbiter #(
  parameter int NumReq   = 4,
  parameter int Width    = 8,
  parameter int MaxBurst = 4
) (
  input  logic                    clk_wr,
  input  logic                    rst_n,
  input  logic [NumReq-1:0]       i_req_valid,
  input  logic [NumReq*Width-1:0] i_req_data,
  output logic [NumReq-1:0]       o_req_ready,
  input  logic                    i_wr_full,
  output logic                    o_wr_en,
  output logic [Width-1:0]        o_wr_data,
  output logic [NumReq-1:0]       o_grant,
  output logic                    o_busy
);

  // state | meaning
  // IDLE  | no grant, all outputs zero, arbitrate from rr_ptr
  // GRANT | requester g owns the write port until burst end or valid drop

  localparam int PtrW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [PtrW-1:0]   g_q, g_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [PtrW:0]     pick;
  logic [PtrW-1:0]   from;
  logic [CntW-1:0]   cnt_inc;
  logic              beat;
  logic              rel;

  // Returns {found, index} of the first valid requester at or after start.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  function automatic logic [PtrW:0] rr_pick(input logic [NumReq-1:0] v,
                                            input logic [PtrW-1:0]   start);
    logic [PtrW:0]   res;
    logic [PtrW-1:0] jj;
    int              j;
    res = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= NumReq) j = j - NumReq;
      jj = PtrW'(j);
      if (v[jj]) res = {1'b1, jj};
    end
    return res;
  endfunction

  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] idx);
    int j;
    j = int'(idx) + 1;
    if (j >= NumReq) j = 0;
    return PtrW'(j);
  endfunction

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    pick        = '0;
    from        = '0;
    cnt_inc     = '0;
    beat        = 1'b0;
    rel         = 1'b0;
    o_req_ready = '0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    o_grant     = '0;
    o_busy      = 1'b0;

    case (state_q)
      IDLE: begin
        pick = rr_pick(i_req_valid, rr_q);
        if (pick[PtrW]) begin
          state_d = GRANT;
          g_d     = pick[PtrW-1:0];
          cnt_d   = '0;
        end
      end

      GRANT: begin
        o_busy           = 1'b1;
        o_grant          = {{(NumReq-1){1'b0}}, 1'b1} << g_q;
        o_req_ready[g_q] = ~i_wr_full;
        beat             = i_req_valid[g_q] & ~i_wr_full;
        o_wr_en          = beat;
        for (int k = 0; k < NumReq; k++) begin
          if (g_q == PtrW'(k)) o_wr_data = i_req_data[k*Width +: Width];
        end

        cnt_inc = cnt_q + 1'b1;
        rel     = ~i_req_valid[g_q] | (beat & (cnt_inc == CntW'(MaxBurst)));

        if (rel) begin
          // Rearbitrate in the same cycle so a waiting requester sees no bubble.
          from  = next_idx(g_q);
          rr_d  = from;
          pick  = rr_pick(i_req_valid, from);
          cnt_d = '0;
          if (pick[PtrW]) begin
            g_d = pick[PtrW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
